sobel_stage: RTL and testbench

SOBEL_STAGE -- requirements
Module: sobel_stage

---
 rtl/img_pkg.sv | 13 +
 rtl/kernel_sum3.sv | 13 +
 rtl/sobel_stage.sv | 121 ++++++++++++
 tb/tb_sobel_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline constants: geometry, mode encodings and the pixel saturation level.
package img_pkg;

  localparam int IMG_W   = 64;
  localparam int PIX_W   = 8;
  localparam int SAT_MAX = 255;

  typedef enum logic {
    MODE_SOBEL = 1'b0,
    MODE_GAUSS = 1'b1
  } mode_e;

endpackage

// File: rtl/kernel_sum3.sv
// a + 2b + c on unsigned operands, purely combinational; result is IN_W+2 bits so it never overflows.
module kernel_sum3 #(
  parameter int IN_W = img_pkg::PIX_W
) (
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  input  logic [IN_W-1:0] c,
  output logic [IN_W+1:0] y
);

  assign y = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};

endmodule

// File: rtl/sobel_stage.sv
// 3x3 Sobel magnitude or 1-2-1 Gaussian blur with optional binary threshold and raster coordinates.
// Fixed 3-cycle latency with no backpressure: in_valid=0 slots travel as bubbles and never stall.
module sobel_stage #(
  parameter int IMG_W = img_pkg::IMG_W,
  parameter int PIX_W = img_pkg::PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix1,
  input  logic [PIX_W-1:0]         pix2,
  input  logic [PIX_W-1:0]         pix3,
  input  logic [PIX_W-1:0]         pix4,
  input  logic [PIX_W-1:0]         pix5,
  input  logic [PIX_W-1:0]         pix6,
  input  logic [PIX_W-1:0]         pix7,
  input  logic [PIX_W-1:0]         pix8,
  input  logic [PIX_W-1:0]         pix9,
  input  logic                     in_valid,
  input  logic                     mode,
  input  logic                     thr_en,
  input  logic [PIX_W-1:0]         thr,
  output logic [PIX_W-1:0]         pixelw,
  output logic                     out_valid,
  output logic [$clog2(IMG_W)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     frame_done
);
  import img_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int SW = PIX_W + 2;  // kernel_sum3 result / |G| width
  localparam int DW = PIX_W + 3;  // signed gradient and |Gx|+|Gy| width
  localparam logic [CW-1:0]    LAST = CW'(IMG_W - 1);
  localparam logic [PIX_W-1:0] SAT  = PIX_W'(SAT_MAX);

  // Row sums feed both Gy and the Gaussian; column sums feed Gx.
  logic [SW-1:0]      r1, r2, r3, c1, c3;
  logic [PIX_W+3:0]   g_sum;
  logic [PIX_W-1:0]   g_pix;
  logic [3:0]         g_frac_unused;

  kernel_sum3 #(.IN_W(PIX_W)) u_row1 (.a(pix1), .b(pix2), .c(pix3), .y(r1));
  kernel_sum3 #(.IN_W(PIX_W)) u_row2 (.a(pix4), .b(pix5), .c(pix6), .y(r2));
  kernel_sum3 #(.IN_W(PIX_W)) u_row3 (.a(pix7), .b(pix8), .c(pix9), .y(r3));
  kernel_sum3 #(.IN_W(PIX_W)) u_col1 (.a(pix1), .b(pix4), .c(pix7), .y(c1));
  kernel_sum3 #(.IN_W(PIX_W)) u_col3 (.a(pix3), .b(pix6), .c(pix9), .y(c3));
  kernel_sum3 #(.IN_W(SW))    u_gauss (.a(r1), .b(r2), .c(r3), .y(g_sum));

  assign {g_pix, g_frac_unused} = g_sum;

  function automatic logic [SW-1:0] mag(input logic [DW-1:0] x);
    return x[DW-1] ? (~x[SW-1:0] + SW'(1)) : x[SW-1:0];
  endfunction

  logic             v1, v2;
  mode_e            m1, m2;
  logic             te1, te2;
  logic [PIX_W-1:0] th1, th2;
  logic [DW-1:0]    gx1, gy1;
  logic [PIX_W-1:0] g1, g2;
  logic [SW-1:0]    ax2, ay2;

  // Datapath registers carry no reset; only the valid chain decides what reaches the output.
  always_ff @(posedge clk) begin
    gx1 <= {1'b0, c3} - {1'b0, c1};
    gy1 <= {1'b0, r3} - {1'b0, r1};
    g1  <= g_pix;
    m1  <= mode_e'(mode);
    te1 <= thr_en;
    th1 <= thr;
    ax2 <= mag(gx1);
    ay2 <= mag(gy1);
    g2  <= g1;
    m2  <= m1;
    te2 <= te1;
    th2 <= th1;
  end

  logic [DW-1:0]    sob_sum;
  logic [PIX_W-1:0] sob_pix, res, pix_next;

  always_comb begin
    sob_sum  = {1'b0, ax2} + {1'b0, ay2};
    sob_pix  = (sob_sum > DW'(SAT_MAX)) ? SAT : sob_sum[PIX_W-1:0];
    res      = (m2 == MODE_GAUSS) ? g2 : sob_pix;
    pix_next = res;
    if (te2) pix_next = (res >= th2) ? SAT : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      pixelw    <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      pixelw    <= v2 ? pix_next : '0;
    end
  end

  // Counters hold the coordinate of the result on the output and step after it is shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_row <= '0;
      out_col <= '0;
    end else if (out_valid) begin
      if (out_col == LAST) begin
        out_col <= '0;
        out_row <= (out_row == LAST) ? '0 : out_row + CW'(1);
      end else begin
        out_col <= out_col + CW'(1);
      end
    end
  end

  assign frame_done = out_valid && (out_row == LAST) && (out_col == LAST);

endmodule

// File: tb/tb_sobel_stage.sv
// Directed checks of sobel_stage: reset, Sobel/Gaussian arithmetic, threshold, framing, mid-flight reset.
module tb_sobel_stage;
  localparam int IMG_W = 64;
  localparam int PIX_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PIX_W-1:0] pw [1:9];
  logic             in_valid = 1'b0;
  logic             mode = 1'b0;
  logic             thr_en = 1'b0;
  logic [PIX_W-1:0] thr = '0;
  logic [PIX_W-1:0] pixelw;
  logic             out_valid;
  logic [5:0]       out_row, out_col;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel_stage #(.IMG_W(IMG_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst),
    .pix1(pw[1]), .pix2(pw[2]), .pix3(pw[3]), .pix4(pw[4]), .pix5(pw[5]),
    .pix6(pw[6]), .pix7(pw[7]), .pix8(pw[8]), .pix9(pw[9]),
    .in_valid(in_valid), .mode(mode), .thr_en(thr_en), .thr(thr),
    .pixelw(pixelw), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [PIX_W-1:0] v);
    for (int i = 1; i <= 9; i++) pw[i] = v;
  endtask

  // One-cycle window, then wait until its result is on the outputs.
  task automatic push_and_wait;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; mode = 1'b1; fill(8'd255);
    tick; tick; tick;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pixelw !== 8'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b pix=%0d fd=%b, expected 0 0 0", out_valid, pixelw, frame_done);
    end
    checks++;
    if (out_row !== 6'd0 || out_col !== 6'd0) begin
      errors++;
      $display("FAIL reset_coords: row=%0d col=%0d, expected 0/0", out_row, out_col);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_ignores_valid: out_valid=%b cycle %0d after reset, expected 0", out_valid, i);
      end
    end
  endtask

  task automatic test_sobel_flat;
    mode = 1'b0; thr_en = 1'b0; fill(8'd100);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flat_latency_early: out_valid=%b at N+2, expected 0", out_valid);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || pixelw !== 8'd0) begin
      errors++;
      $display("FAIL flat_result: valid=%b pix=%0d, expected 1 0", out_valid, pixelw);
    end
    checks++;
    if (out_row !== 6'd0 || out_col !== 6'd0) begin
      errors++;
      $display("FAIL flat_coords: row=%0d col=%0d, expected 0/0", out_row, out_col);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0 || pixelw !== 8'd0) begin
      errors++;
      $display("FAIL idle_zero: valid=%b pix=%0d, expected 0 0", out_valid, pixelw);
    end
  endtask

  task automatic test_sobel_sat;
    mode = 1'b0; thr_en = 1'b0; fill(8'd0);
    pw[3] = 8'd255; pw[6] = 8'd255; pw[9] = 8'd255;
    push_and_wait;
    checks++;
    if (out_valid !== 1'b1 || pixelw !== 8'd255) begin
      errors++;
      $display("FAIL sobel_sat: valid=%b pix=%0d, expected 1 255", out_valid, pixelw);
    end
    checks++;
    if (out_row !== 6'd0 || out_col !== 6'd1) begin
      errors++;
      $display("FAIL second_coords: row=%0d col=%0d, expected 0/1", out_row, out_col);
    end
  endtask

  task automatic test_sobel_thr;
    logic [PIX_W-1:0] exp_pix [0:2];
    logic [PIX_W-1:0] thr_val [0:2];
    logic             en_val  [0:2];
    exp_pix = '{8'd40, 8'd0, 8'd255};
    thr_val = '{8'd0, 8'd50, 8'd40};
    en_val  = '{1'b0, 1'b1, 1'b1};
    mode = 1'b0; fill(8'd0);
    pw[3] = 8'd10; pw[6] = 8'd10; pw[9] = 8'd10;
    for (int i = 0; i < 3; i++) begin
      thr_en = en_val[i]; thr = thr_val[i];
      push_and_wait;
      checks++;
      if (out_valid !== 1'b1 || pixelw !== exp_pix[i]) begin
        errors++;
        $display("FAIL thr_case%0d: valid=%b pix=%0d, expected 1 %0d", i, out_valid, pixelw, exp_pix[i]);
      end
    end
    // Threshold change after sampling must not reach the in-flight window.
    thr_en = 1'b1; thr = 8'd40;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0; thr = 8'd200; thr_en = 1'b0;
    tick; tick;
    checks++;
    if (pixelw !== 8'd255) begin
      errors++;
      $display("FAIL thr_inflight: pix=%0d, expected 255", pixelw);
    end
    // Negative Gx and diagonal gradients exercise the absolute value.
    thr_en = 1'b0; fill(8'd0);
    pw[1] = 8'd10; pw[4] = 8'd10; pw[7] = 8'd10;
    push_and_wait;
    checks++;
    if (pixelw !== 8'd40) begin
      errors++;
      $display("FAIL sobel_neg_gx: pix=%0d, expected 40", pixelw);
    end
    fill(8'd0); pw[1] = 8'd100;
    push_and_wait;
    checks++;
    if (pixelw !== 8'd200) begin
      errors++;
      $display("FAIL sobel_diag: pix=%0d, expected 200", pixelw);
    end
  endtask

  task automatic test_gauss;
    thr_en = 1'b0; mode = 1'b1; fill(8'd255);
    push_and_wait;
    checks++;
    if (out_valid !== 1'b1 || pixelw !== 8'd255) begin
      errors++;
      $display("FAIL gauss_full: valid=%b pix=%0d, expected 1 255", out_valid, pixelw);
    end
    fill(8'd0); pw[5] = 8'd16;
    push_and_wait;
    checks++;
    if (pixelw !== 8'd4) begin
      errors++;
      $display("FAIL gauss_centre: pix=%0d, expected 4", pixelw);
    end
    // pix9=100: Gaussian 100>>4 = 6, Sobel |100|+|100| = 200.
    fill(8'd0); pw[9] = 8'd100;
    in_valid = 1'b1; mode = 1'b1;
    tick;
    mode = 1'b0;
    tick;
    mode = 1'b1;
    tick;
    in_valid = 1'b0; mode = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || pixelw !== 8'd6) begin
      errors++;
      $display("FAIL toggle_a: valid=%b pix=%0d, expected 1 6", out_valid, pixelw);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || pixelw !== 8'd200) begin
      errors++;
      $display("FAIL toggle_b: valid=%b pix=%0d, expected 1 200", out_valid, pixelw);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || pixelw !== 8'd6) begin
      errors++;
      $display("FAIL toggle_c: valid=%b pix=%0d, expected 1 6", out_valid, pixelw);
    end
    tick;
  endtask

  task automatic test_frame;
    int seen = 0;
    int cyc = 0;
    int fd_count = 0;
    rst = 1'b1;
    tick;
    rst = 1'b0; mode = 1'b1; thr_en = 1'b0;
    fork
      begin
        for (int k = 0; k < IMG_W * IMG_W + 1; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick;
          end
          fill(PIX_W'(k));
          in_valid = 1'b1;
          tick;
        end
        in_valid = 1'b0;
      end
      begin
        while (seen < IMG_W * IMG_W + 1 && cyc < 20000) begin
          @(posedge clk);
          #1;
          cyc++;
          if (frame_done === 1'b1) fd_count++;
          if (out_valid === 1'b1) begin
            checks++;
            if (out_row !== 6'((seen / IMG_W) % IMG_W) || out_col !== 6'(seen % IMG_W)) begin
              errors++;
              $display("FAIL frame_coords: result %0d at %0d/%0d, expected %0d/%0d", seen, out_row, out_col,
                       (seen / IMG_W) % IMG_W, seen % IMG_W);
            end
            checks++;
            if (pixelw !== PIX_W'(seen)) begin
              errors++;
              $display("FAIL frame_pixel: result %0d pix=%0d, expected %0d", seen, pixelw, seen % 256);
            end
            checks++;
            if (frame_done !== (seen == IMG_W * IMG_W - 1)) begin
              errors++;
              $display("FAIL frame_done: result %0d fd=%b, expected %b", seen, frame_done,
                       seen == IMG_W * IMG_W - 1);
            end
            seen++;
          end
        end
      end
    join
    checks++;
    if (seen != IMG_W * IMG_W + 1) begin
      errors++;
      $display("FAIL frame_timeout: %0d results seen, expected %0d", seen, IMG_W * IMG_W + 1);
    end
    checks++;
    if (fd_count != 1) begin
      errors++;
      $display("FAIL frame_done_count: %0d pulses, expected 1", fd_count);
    end
    tick; tick; tick;
  endtask

  task automatic test_reset_midflight;
    mode = 1'b1; thr_en = 1'b0; fill(8'd255);
    in_valid = 1'b1;
    tick;
    tick;
    in_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (out_row !== 6'd0 || out_col !== 6'd0) begin
      errors++;
      $display("FAIL midreset_coords: row=%0d col=%0d, expected 0/0", out_row, out_col);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0 || pixelw !== 8'd0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL midreset_flush%0d: valid=%b pix=%0d fd=%b, expected 0 0 0", i, out_valid, pixelw, frame_done);
      end
      tick;
    end
    fill(8'd0); pw[5] = 8'd16;
    push_and_wait;
    checks++;
    if (out_valid !== 1'b1 || pixelw !== 8'd4 || out_row !== 6'd0 || out_col !== 6'd0) begin
      errors++;
      $display("FAIL midreset_restart: valid=%b pix=%0d at %0d/%0d, expected 1 4 at 0/0", out_valid, pixelw,
               out_row, out_col);
    end
  endtask

  initial begin
    fill(8'd0);
    test_reset;
    test_sobel_flat;
    test_sobel_sat;
    test_sobel_thr;
    test_gauss;
    test_frame;
    test_reset_midflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
